// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor: D = X - Y - Bin (mod 256), LSB first, one bit per clock.
// The FSM runs IDLE -> SHIFT (8 cycles) -> DONE (1 cycle) -> IDLE.
module serial_subtractor_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic       Bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] D,
    output logic       Bout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [7:0] res_q;
    logic [7:0] d_q;
    logic       b_q;
    logic       bout_q;
    logic [2:0] cnt_q;

    logic       diff_d;
    logic       borrow_d;
    logic [7:0] res_d;

    function automatic logic borrow_next(input logic x0, input logic y0, input logic b);
        return (~x0 & y0) | (~(x0 ^ y0) & b);
    endfunction

    always_comb begin
        diff_d   = x_q[0] ^ y_q[0] ^ b_q;
        borrow_d = borrow_next(x_q[0], y_q[0], b_q);
        res_d    = {diff_d, res_q[7:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            res_q   <= 8'h00;
            d_q     <= 8'h00;
            b_q     <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= X;
                        y_q     <= Y;
                        b_q     <= Bin;
                        cnt_q   <= 3'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    x_q   <= {1'b0, x_q[7:1]};
                    y_q   <= {1'b0, y_q[7:1]};
                    res_q <= res_d;
                    b_q   <= borrow_d;
                    cnt_q <= cnt_q + 3'd1;
                    // Last bit: publish the assembled result straight from the shifter input.
                    if (cnt_q == 3'd7) begin
                        d_q     <= res_d;
                        bout_q  <= borrow_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign D    = d_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for serial_subtractor_8bit: spec-level timing/arithmetic model checked every cycle,
// plus directed cases with literal expected results.
module tb_serial_subtractor_8bit;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] X     = 8'h00;
    logic [7:0] Y     = 8'h00;
    logic       Bin   = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic       Bout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_subtractor_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: t = cycles elapsed since the accepting edge (-1 when idle).
    int         t      = -1;
    logic [7:0] pend_d = 8'h00;
    logic       pend_b = 1'b0;
    logic [7:0] exp_d  = 8'h00;
    logic       exp_b  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t     = -1;
            exp_d = 8'h00;
            exp_b = 1'b0;
        end else if (t < 0) begin
            if (start) begin
                t      = 0;
                pend_d = 8'((int'(X) - int'(Y) - int'(Bin)) & 255);
                pend_b = (int'(X) < int'(Y) + int'(Bin));
            end
        end else begin
            t++;
            if (t == 8) begin
                exp_d = pend_d;
                exp_b = pend_b;
            end else if (t == 9) begin
                t = -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", int'(busy), int'(t >= 0 && t <= 7));
        chk("cyc_done", int'(done), int'(t == 8));
        chk("cyc_D",    int'(D),    int'(exp_d));
        chk("cyc_Bout", int'(Bout), int'(exp_b));
    end

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic b,
                         input logic [7:0] ed, input logic eb, input string nm);
        int n;
        int busy_n;
        bit seen;
        @(posedge clk); #2;
        X = x; Y = y; Bin = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        X = 8'($urandom); Y = 8'($urandom); Bin = 1'($urandom);
        n = 1; busy_n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_n++;
                @(posedge clk); #2;
                X = 8'($urandom); Y = 8'($urandom); Bin = 1'($urandom);
                n++;
            end
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_latency"},   n, 9);
        chk({nm, "_busy_cyc"},  busy_n, 8);
        chk({nm, "_D"},         int'(D), int'(ed));
        chk({nm, "_Bout"},      int'(Bout), int'(eb));
    endtask

    logic [7:0] hx [3] = '{8'd9, 8'd3, 8'd128};
    logic [7:0] hy [3] = '{8'd4, 8'd8, 8'd127};
    logic       hb [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] hd [3] = '{8'd5, 8'd251, 8'd0};
    logic       ho [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int ndone;
        int dcyc [3];
        logic [7:0] dval;
        logic       bval;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_D",    int'(D),    0);
        chk("rst_Bout", int'(Bout), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(8'd100, 8'd37,  1'b0, 8'h3F, 1'b0, "sub_100_37");
        do_op(8'd37,  8'd100, 1'b0, 8'hC1, 1'b1, "sub_37_100");
        do_op(8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, "sub_0_0_bin");
        do_op(8'd37,  8'd100, 1'b0, 8'hC1, 1'b1, "sub_37_100_again");

        // Reset in the 4th SHIFT cycle.
        @(posedge clk); #2;
        X = 8'd200; Y = 8'd1; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_D",    int'(D),    0);
        chk("midrst_Bout", int'(Bout), 0);
        #3 rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        do_op(8'd10, 8'd3, 1'b0, 8'd7, 1'b0, "recover_10_3");
        do_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "sub_ff_ff");

        // Second start during a run must be ignored.
        @(posedge clk); #2;
        X = 8'd50; Y = 8'd20; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        X = 8'd1; Y = 8'd2; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; X = 8'd77; Y = 8'd200;
        ndone = 0; dval = 8'h00; bval = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                dval = D;
                bval = Bout;
            end
        end
        chk("ignore_start_ndone", ndone, 1);
        chk("ignore_start_D",     int'(dval), 30);
        chk("ignore_start_Bout",  int'(bval), 0);

        // Start held high: back-to-back operations.
        @(posedge clk); #2;
        X = hx[0]; Y = hy[0]; Bin = hb[0]; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc[ndone] = cyc;
                chk($sformatf("held_D%0d", ndone),    int'(D),    int'(hd[ndone]));
                chk($sformatf("held_Bout%0d", ndone), int'(Bout), int'(ho[ndone]));
                ndone++;
                if (ndone < 3) begin
                    X = hx[ndone]; Y = hy[ndone]; Bin = hb[ndone];
                end
            end
        end
        start = 1'b0;
        chk("held_ndone", ndone, 3);
        if (ndone == 3) begin
            chk("held_gap1", dcyc[1] - dcyc[0], 10);
            chk("held_gap2", dcyc[2] - dcyc[1], 10);
        end

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            X     = 8'($urandom);
            Y     = 8'($urandom);
            Bin   = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 The port list SHALL be, in order, with clock and reset first:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin one subtraction.
- X  input  8  minuend.
- Y  input  8  subtrahend.
- Bin  input  1  borrow-in.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse marking a new result.
- D  output  8  difference, X - Y - Bin modulo 256.
- Bout  output  1  borrow-out.
REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.

Function
REQ-004 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-005 In IDLE with start=1 at a rising edge, the block SHALL:
- load X and Y into internal 8-bit shift registers;
- load Bin into the borrow flop;
- clear the 3-bit bit counter;
- enter SHIFT.
REQ-006 In SHIFT, each cycle, the block SHALL process LSB-first using x0 and y0, the LSBs of the operand shift registers, and b, the borrow flop:
- diff bit = x0 ^ y0 ^ b;
- next borrow = (~x0 & y0) | (~(x0 ^ y0) & b).
REQ-007 In SHIFT, each cycle, the block SHALL:
- right-shift both operand registers;
- shift the diff bit into the MSB of an internal result register;
- increment the counter.
REQ-008 When the counter equals 7 in SHIFT, the block SHALL, at that edge:
- enter DONE;
- copy the completed result into D;
- copy the final borrow into Bout.
REQ-009 The block SHALL stay in SHIFT for exactly 8 cycles.
REQ-010 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+8, and D/Bout SHALL be valid from that same cycle.
REQ-011 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-012 done SHALL equal (state==DONE).
REQ-013 busy SHALL equal (state==SHIFT).
REQ-014 D and Bout SHALL change only at the edge that enters DONE, and SHALL hold their value until the next completion.
REQ-015 start SHALL be ignored in SHIFT and DONE; the operation in flight SHALL be unaffected.
REQ-016 A start held continuously SHALL begin a new operation at the first edge in IDLE, giving back-to-back operations every 10 cycles.
REQ-017 X, Y and Bin SHALL be sampled only at the accepting edge; later changes SHALL not affect the result.
REQ-018 Arithmetic SHALL be unsigned modulo 256: Bout=1 exactly when X < Y + Bin, treating the sum as an integer.

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for a clock, force:
- state to IDLE;
- busy=0, done=0;
- D=8'h00, Bout=0;
- operand registers, result register, borrow flop and counter to zero.
REQ-020 A reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow, and D/Bout SHALL read zero.
REQ-021 After rst_n deasserts, the first start sampled at a rising edge with rst_n=1 SHALL be accepted normally.

Verification
REQ-022 X=100, Y=37, Bin=0, start pulsed -> busy for 8 cycles; done in the 9th cycle after the accepting edge; D=63 (8'h3F), Bout=0.
REQ-023 X=37, Y=100, Bin=0 -> D=8'hC1 (193), Bout=1.
REQ-024 Two boundary cases SHALL be covered:
- X=0, Y=0, Bin=1 -> D=8'hFF, Bout=1.
- X=8'hFF, Y=8'hFF, Bin=0 -> D=8'h00, Bout=0.
REQ-025 During a run of X=50, Y=20, pulse start again with X=1, Y=2 and change X/Y mid-run -> a single done; D=30 (8'h1E), Bout=0; no second operation starts.
REQ-026 Reset mid-run and recovery:
- Start X=200, Y=1; assert rst_n=0 during the 4th SHIFT cycle -> busy=0, D=0, Bout=0 immediately; no done pulse.
- After release, start X=10, Y=3, Bin=0 -> D=7, Bout=0.
REQ-027 Hold start=1 for three operations -> done pulses exactly 10 cycles apart, each with the correct D.
